// File: rtl/galaga_pkg.sv
// Shared game types and constants used by the round bookkeeping and the state controller.
package galaga_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODING = 2'd1,
    RESPAWN   = 2'd2,
    OUT       = 2'd3
  } player_state_t;

  localparam int          N_ENEMIES_DEF   = 20;
  localparam int          START_LIVES_DEF = 3;
  localparam logic [15:0] POINTS_DEF      = 16'd50;

  localparam logic [7:0]  KEY_ENTER       = 8'h28;

endpackage

// File: rtl/fleet_status_tracker_frame_timer.sv
// 6-bit frame-tick counter; done is asserted combinationally on the tick that reaches target.
module frame_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [5:0] target,
  output logic       done
);

  logic [5:0] count_reg;

  assign done = tick && !clear && (count_reg == target);

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count_reg <= 6'd0;
    end else if (tick) begin
      count_reg <= (count_reg == target) ? 6'd0 : count_reg + 6'd1;
    end
  end

endmodule

// File: rtl/fleet_status_tracker.sv
// Per-round bookkeeping: enemy alive mask, score, lives and the player explode/respawn sequence.
module fleet_status_tracker
  import galaga_pkg::*;
#(
  parameter int          N_ENEMIES      = N_ENEMIES_DEF,
  parameter int          START_LIVES    = START_LIVES_DEF,
  parameter logic [15:0] POINTS         = POINTS_DEF,
  parameter logic [5:0]  EXPLODE_FRAMES = 6'd30,
  parameter logic [5:0]  INVULN_FRAMES  = 6'd60
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 play,
  input  logic                 frame_tick,
  input  logic                 enemy_hit,
  input  logic [4:0]           enemy_hit_idx,
  input  logic                 player_hit,
  output logic [N_ENEMIES-1:0] enemy_alive,
  output logic [1:0]           lives,
  output logic [15:0]          score,
  output logic                 invuln,
  output logic                 exploding,
  output logic                 died,
  output logic                 killed_all
);

  logic [N_ENEMIES-1:0] alive_reg, alive_next;
  logic [1:0]           lives_reg, lives_next;
  logic [15:0]          score_reg;
  logic [16:0]          score_sum;
  logic                 invuln_reg, exploding_reg, died_reg, killed_all_reg;
  player_state_t        state_reg, state_next;
  logic                 kill;
  logic                 timer_clear, timer_tick, timer_done;
  logic [5:0]           timer_target;

  assign kill = play && !start && enemy_hit && (32'(enemy_hit_idx) < N_ENEMIES)
                && alive_reg[enemy_hit_idx];

  genvar gi;
  generate
    for (gi = 0; gi < N_ENEMIES; gi++) begin : g_alive
      assign alive_next[gi] = start ? 1'b1 :
                              (kill && enemy_hit_idx == 5'(gi)) ? 1'b0 : alive_reg[gi];
    end
  endgenerate

  // Score saturates rather than wrapping.
  assign score_sum = {1'b0, score_reg} + {1'b0, POINTS};

  assign timer_target = (state_reg == EXPLODING) ? EXPLODE_FRAMES - 6'd1 : INVULN_FRAMES - 6'd1;
  assign timer_tick   = play && !start && frame_tick &&
                        (state_reg == EXPLODING || state_reg == RESPAWN);

  frame_timer u_frame_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (timer_clear),
    .tick   (timer_tick),
    .target (timer_target),
    .done   (timer_done)
  );

  always_comb begin
    state_next  = state_reg;
    lives_next  = lives_reg;
    timer_clear = 1'b0;
    if (start) begin
      state_next  = ALIVE;
      lives_next  = 2'(START_LIVES);
      timer_clear = 1'b1;
    end else if (play) begin
      case (state_reg)
        ALIVE: begin
          if (player_hit) begin
            if (lives_reg > 2'd1) begin
              lives_next  = lives_reg - 2'd1;
              state_next  = EXPLODING;
              timer_clear = 1'b1;
            end else begin
              lives_next = 2'd0;
              state_next = OUT;
            end
          end
        end
        EXPLODING: if (timer_done) state_next = RESPAWN;
        RESPAWN:   if (timer_done) state_next = ALIVE;
        default:   state_next = OUT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= ALIVE;
      alive_reg      <= '1;
      lives_reg      <= 2'(START_LIVES);
      score_reg      <= 16'd0;
      invuln_reg     <= 1'b0;
      exploding_reg  <= 1'b0;
      died_reg       <= 1'b0;
      killed_all_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      alive_reg      <= alive_next;
      lives_reg      <= lives_next;
      invuln_reg     <= (state_next == EXPLODING) || (state_next == RESPAWN);
      exploding_reg  <= (state_next == EXPLODING);
      died_reg       <= (state_next == OUT);
      killed_all_reg <= (alive_next == '0);
      if (start) begin
        score_reg <= 16'd0;
      end else if (kill) begin
        score_reg <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end

  assign enemy_alive = alive_reg;
  assign lives       = lives_reg;
  assign score       = score_reg;
  assign invuln      = invuln_reg;
  assign exploding   = exploding_reg;
  assign died        = died_reg;
  assign killed_all  = killed_all_reg;

endmodule

// File: tb/tb_fleet_status_tracker.sv
// Scoreboard bench for fleet_status_tracker: a reference model queues expected snapshots per cycle.
module tb_fleet_status_tracker;

  localparam int NE = 20;
  typedef logic [NE+21:0] snap_t;

  logic          clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start = 1'b0;
  logic          play = 1'b0;
  logic          frame_tick = 1'b0;
  logic          enemy_hit = 1'b0;
  logic [4:0]    enemy_hit_idx = 5'd0;
  logic          player_hit = 1'b0;
  logic [NE-1:0] enemy_alive;
  logic [1:0]    lives;
  logic [15:0]   score;
  logic          invuln, exploding, died, killed_all;

  fleet_status_tracker dut (
    .Clk           (clk),
    .Reset         (Reset),
    .start         (start),
    .play          (play),
    .frame_tick    (frame_tick),
    .enemy_hit     (enemy_hit),
    .enemy_hit_idx (enemy_hit_idx),
    .player_hit    (player_hit),
    .enemy_alive   (enemy_alive),
    .lives         (lives),
    .score         (score),
    .invuln        (invuln),
    .exploding     (exploding),
    .died          (died),
    .killed_all    (killed_all)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic cur_play = 1'b0;

  // Reference model (0 ALIVE, 1 EXPLODING, 2 RESPAWN, 3 OUT)
  logic [NE-1:0] m_alive = '1;
  int m_lives = 3, m_score = 0, m_state = 0, m_cnt = 0;

  snap_t exp_q[$];
  snap_t act_q[$];
  snap_t e, a;

  function automatic snap_t dut_snap();
    return {enemy_alive, lives, score, invuln, exploding, died, killed_all};
  endfunction

  task automatic cycle(input logic rst, input logic st, input logic ft, input logic eh,
                       input logic [4:0] idx, input logic ph);
    Reset = rst; start = st; play = cur_play; frame_tick = ft;
    enemy_hit = eh; enemy_hit_idx = idx; player_hit = ph;
    if (rst || st) begin
      m_alive = '1; m_lives = 3; m_score = 0; m_state = 0; m_cnt = 0;
    end else if (cur_play) begin
      if (eh && idx < NE && m_alive[idx]) begin
        m_alive[idx] = 1'b0;
        m_score = (m_score + 50 > 65535) ? 65535 : m_score + 50;
      end
      if (m_state == 0 && ph) begin
        if (m_lives > 1) begin m_lives--; m_cnt = 0; m_state = 1; end
        else begin m_lives = 0; m_state = 3; end
      end else if ((m_state == 1 || m_state == 2) && ft) begin
        if (m_cnt == ((m_state == 1) ? 29 : 59)) begin
          m_cnt = 0; m_state = (m_state == 1) ? 2 : 0;
        end else m_cnt++;
      end
    end
    exp_q.push_back({m_alive, 2'(m_lives), 16'(m_score), (m_state == 1 || m_state == 2),
                     (m_state == 1), (m_state == 3), (m_alive == '0)});
    @(posedge clk); #1;
    act_q.push_back(dut_snap());
    Reset = 1'b0; start = 1'b0; frame_tick = 1'b0; enemy_hit = 1'b0; player_hit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic hit_enemy(input logic [4:0] idx);
    cycle(0, 0, 0, 1, idx, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(0, 0, 1, 0, 5'd0, 0);
      cycle(0, 0, 0, 0, 5'd0, 0);
    end
  endtask

  task automatic lose_life_and_recover();
    cycle(0, 0, 0, 0, 5'd0, 1);
    ticks(90);
  endtask

  task automatic test_reset();
    cur_play = 1'b0;
    cycle(1, 0, 0, 0, 5'd0, 0);
    idle(1);
    n_checks++;
    if ({enemy_alive, lives, score, invuln, exploding, died, killed_all} !== {{NE{1'b1}}, 2'd3, 16'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reset_values: got alive=%h lives=%0d score=%0d flags=%b%b%b%b, want alive=fffff lives=3 score=0 flags=0000",
                         enemy_alive, lives, score, invuln, exploding, died, killed_all);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_kill_all();
    cycle(1, 0, 0, 0, 5'd0, 0);
    cur_play = 1'b1;
    for (int i = 0; i < NE; i++) begin
      hit_enemy(5'(i));
      if (i == NE - 1) begin
        n_checks++;
        if (killed_all !== 1'b1 || enemy_alive !== '0) begin
          n_fail++; $display("FAIL killed_all_rise: got killed_all=%b alive=%h, want 1 and 0", killed_all, enemy_alive);
        end
      end else if (i == NE - 2) begin
        n_checks++;
        if (killed_all !== 1'b0) begin
          n_fail++; $display("FAIL killed_all_early: got %b want 0", killed_all);
        end
      end
      idle(2);
    end
    n_checks++;
    if (score !== 16'd1000) begin n_fail++; $display("FAIL score_1000: got %0d want 1000", score); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL kill_all_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_duplicate_and_range();
    cycle(1, 0, 0, 0, 5'd0, 0);
    hit_enemy(5'd5);
    hit_enemy(5'd5);
    hit_enemy(5'd25);
    idle(1);
    n_checks++;
    if (score !== 16'd50 || enemy_alive !== 20'hFFFDF) begin
      n_fail++; $display("FAIL dup_range: got score=%0d alive=%h, want 50 fffdf", score, enemy_alive);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL dup_range_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_explode_respawn();
    cycle(1, 0, 0, 0, 5'd0, 0);
    cycle(0, 0, 0, 0, 5'd0, 1);
    n_checks++;
    if ({lives, exploding, invuln} !== {2'd2, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL explode_entry: got lives=%0d expl=%b inv=%b, want 2 1 1", lives, exploding, invuln);
    end
    ticks(29);
    n_checks++;
    if (exploding !== 1'b1) begin n_fail++; $display("FAIL explode_29: got exploding=%b want 1", exploding); end
    cycle(0, 0, 1, 0, 5'd0, 0);
    n_checks++;
    if ({exploding, invuln} !== 2'b01) begin
      n_fail++; $display("FAIL respawn_entry: got expl=%b inv=%b, want 0 1", exploding, invuln);
    end
    cycle(0, 0, 0, 0, 5'd0, 1);
    n_checks++;
    if (lives !== 2'd2) begin n_fail++; $display("FAIL invuln_hit: got lives=%0d want 2", lives); end
    ticks(59);
    n_checks++;
    if (invuln !== 1'b1) begin n_fail++; $display("FAIL respawn_59: got invuln=%b want 1", invuln); end
    cycle(0, 0, 1, 0, 5'd0, 0);
    n_checks++;
    if (invuln !== 1'b0) begin n_fail++; $display("FAIL respawn_done: got invuln=%b want 0", invuln); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL explode_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_game_over_restart();
    cycle(1, 0, 0, 0, 5'd0, 0);
    lose_life_and_recover();
    lose_life_and_recover();
    cycle(0, 0, 0, 0, 5'd0, 1);
    n_checks++;
    if ({died, lives} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL game_over: got died=%b lives=%0d, want 1 0", died, lives);
    end
    hit_enemy(5'd3);
    cycle(0, 1, 0, 0, 5'd0, 0);
    n_checks++;
    if ({lives, died, enemy_alive, score} !== {2'd3, 1'b0, {NE{1'b1}}, 16'd0}) begin
      n_fail++; $display("FAIL restart: got lives=%0d died=%b alive=%h score=%0d, want 3 0 fffff 0",
                         lives, died, enemy_alive, score);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL game_over_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_simultaneous_end();
    cycle(1, 0, 0, 0, 5'd0, 0);
    for (int i = 0; i < NE - 1; i++) hit_enemy(5'(i));
    lose_life_and_recover();
    lose_life_and_recover();
    cycle(0, 0, 0, 1, 5'(NE - 1), 1);
    n_checks++;
    if ({died, killed_all} !== 2'b11) begin
      n_fail++; $display("FAIL simultaneous: got died=%b killed_all=%b, want 1 1", died, killed_all);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL simultaneous_sb: got %h want %h", a, e); end
    end
  endtask

  task automatic test_freeze_and_reset_mid_explode();
    cycle(1, 0, 0, 0, 5'd0, 0);
    cycle(0, 0, 0, 0, 5'd0, 1);
    ticks(10);
    cur_play = 1'b0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 5'(i), 1);
    n_checks++;
    if ({exploding, lives, enemy_alive, score} !== {1'b1, 2'd2, {NE{1'b1}}, 16'd0}) begin
      n_fail++; $display("FAIL freeze: got expl=%b lives=%0d alive=%h score=%0d, want 1 2 fffff 0",
                         exploding, lives, enemy_alive, score);
    end
    cur_play = 1'b1;
    cycle(1, 0, 1, 1, 5'd2, 1);
    n_checks++;
    if ({enemy_alive, lives, score, invuln, exploding, died, killed_all} !== {{NE{1'b1}}, 2'd3, 16'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reset_mid_explode: got alive=%h lives=%0d score=%0d flags=%b%b%b%b, want fffff 3 0 0000",
                         enemy_alive, lives, score, invuln, exploding, died, killed_all);
    end
    cycle(0, 0, 0, 0, 5'd0, 1);
    ticks(29);
    n_checks++;
    if (exploding !== 1'b1) begin n_fail++; $display("FAIL counter_cleared: got exploding=%b want 1", exploding); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL freeze_sb: got %h want %h", a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_kill_all();
    test_duplicate_and_range();
    test_explode_respawn();
    test_game_over_restart();
    test_simultaneous_end();
    test_freeze_and_reset_mid_explode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
